if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 168 ++++++++++++++++
 tb/tb_if_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage. Issues word-aligned fetch requests to
//             the ICache, delivers the fetched instruction and its PC to the
//             IF/ID register, honours downstream stalls, and redirects on
//             taken branches and jumps, discarding stale responses.
//  Options  : IF_FETCH_CNT_EN - adds if_fetch_cnt_o, a wrapping count of
//             delivered instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_flush_btype_flag_i,
    input  logic [31:0] fc_btype_addr_i,
    input  logic        fc_flush_jtype_flag_i,
    input  logic [31:0] fc_jtype_addr_i,
    input  logic        fc_stall_if_i,
    output logic        if_icache_req_o,
    output logic [31:0] if_icache_addr_o,
    input  logic        icache_if_ready_i,
    input  logic        icache_if_valid_i,
    input  logic [31:0] icache_if_inst_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] if_fetch_cnt_o
`endif
);

    // IDLE : one cycle after reset release
    // REQ  : request presented, waiting for ICache acceptance
    // WAIT : request accepted, waiting for the response
    // HOLD : instruction delivered, downstream stalled
    // DROP : accepted request made stale by a redirect; swallow its response
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] inst_q,     inst_d;
    logic        valid_q,    valid_d;
    logic        deliver;

    // Branch beats jump when both fire; targets are always word aligned.
    logic        redirect;
    logic [31:0] redir_target;

    assign redirect     = fc_flush_btype_flag_i | fc_flush_jtype_flag_i;
    assign redir_target = (fc_flush_btype_flag_i ? fc_btype_addr_i : fc_jtype_addr_i)
                          & 32'hFFFF_FFFC;

    // Next-state, next fetch address and delivery register update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = 1'b0;
        deliver    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) fetch_pc_d = redir_target;
            end

            S_REQ: begin
                // Stall is deliberately ignored here: a pending request always proceeds.
                if (redirect) begin
                    fetch_pc_d = redir_target;
                    // If the ICache took the old address this cycle, its
                    // response is now stale and must be swallowed.
                    state_d    = icache_if_ready_i ? S_DROP : S_REQ;
                end else if (icache_if_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redir_target;
                    // A response arriving together with the redirect is simply
                    // ignored; otherwise it is still in flight and must be dropped.
                    state_d    = icache_if_valid_i ? S_REQ : S_DROP;
                end else if (icache_if_valid_i) begin
                    pc_d       = fetch_pc_q;
                    inst_d     = icache_if_inst_i;
                    valid_d    = 1'b1;
                    deliver    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = fc_stall_if_i ? S_HOLD : S_REQ;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_d = redir_target;
                    state_d    = S_REQ;
                end else if (fc_stall_if_i) begin
                    valid_d = valid_q;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect) fetch_pc_d = redir_target;
                if (icache_if_valid_i) state_d = S_REQ;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, fetch address and delivered-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    assign if_icache_req_o  = (state_q == S_REQ);
    assign if_icache_addr_o = fetch_pc_q;
    assign if_pc_o          = pc_q;
    assign if_inst_o        = inst_q;
    assign if_valid_o       = valid_q;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Count each newly delivered instruction; HOLD cycles do not add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
        end else if (deliver) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign if_fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage. An ICache stub answers
//             accepted requests; a transaction-level model (pending fetch,
//             discard, hold flags) predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fc_flush_btype_flag_i = 1'b0;
    logic [31:0] fc_btype_addr_i       = 32'd0;
    logic        fc_flush_jtype_flag_i = 1'b0;
    logic [31:0] fc_jtype_addr_i       = 32'd0;
    logic        fc_stall_if_i         = 1'b0;
    logic        if_icache_req_o;
    logic [31:0] if_icache_addr_o;
    logic        icache_if_ready_i     = 1'b0;
    logic        icache_if_valid_i     = 1'b0;
    logic [31:0] icache_if_inst_i      = 32'd0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] if_fetch_cnt_o;
`endif

    if_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fc_flush_btype_flag_i (fc_flush_btype_flag_i),
        .fc_btype_addr_i       (fc_btype_addr_i),
        .fc_flush_jtype_flag_i (fc_flush_jtype_flag_i),
        .fc_jtype_addr_i       (fc_jtype_addr_i),
        .fc_stall_if_i         (fc_stall_if_i),
        .if_icache_req_o       (if_icache_req_o),
        .if_icache_addr_o      (if_icache_addr_o),
        .icache_if_ready_i     (icache_if_ready_i),
        .icache_if_valid_i     (icache_if_valid_i),
        .icache_if_inst_i      (icache_if_inst_i),
        .if_pc_o               (if_pc_o),
        .if_inst_o             (if_inst_o),
        .if_valid_o            (if_valid_o)
`ifdef IF_FETCH_CNT_EN
        ,
        .if_fetch_cnt_o        (if_fetch_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_started;   // first cycle after reset has elapsed
    bit          m_out;       // an accepted fetch awaits its response
    bit          m_disc;      // that outstanding response is stale
    bit          m_hold;      // delivered instruction frozen by stall
    logic [31:0] m_pc;        // next address to fetch
    bit          m_valid;
    logic [31:0] m_pco, m_insto;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        m_started = 0; m_out = 0; m_disc = 0; m_hold = 0;
        m_pc = C_RESET_PC; m_valid = 0; m_pco = 0; m_insto = 0; m_cnt = 0;
    endfunction

    function automatic bit model_requesting();
        return m_started && !m_out && !m_hold;
    endfunction

    function automatic void model_update(input bit bt, input logic [31:0] bta,
                                         input bit jt, input logic [31:0] jta,
                                         input bit st, input bit rdy,
                                         input bit vld, input logic [31:0] inst);
        bit          redir;
        logic [31:0] tgt;
        redir = bt || jt;
        tgt   = (bt ? bta : jta) & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
        end else if (m_hold) begin
            if (redir) begin
                m_pc = tgt; m_hold = 0; m_valid = 0;
            end else if (!st) begin
                m_hold = 0; m_valid = 0;
            end
        end else if (!m_out) begin
            m_valid = 0;
            if (redir) m_pc = tgt;
            if (rdy) begin
                m_out  = 1;
                m_disc = redir;
            end
        end else begin
            m_valid = 0;
            if (redir) begin
                m_pc = tgt;
                if (vld) m_out = 0;
                else     m_disc = 1;
            end else if (vld) begin
                m_out = 0;
                if (!m_disc) begin
                    m_pco   = m_pc;
                    m_insto = inst;
                    m_valid = 1;
                    m_pc    = m_pc + 32'd4;
                    m_hold  = st;
                    m_cnt   = m_cnt + 32'd1;
                end
            end
        end
    endfunction

    // ---------------- ICache stub ----------------
    bit          st_pend;
    logic [31:0] st_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic compare_all();
        check_eq("req",   {31'd0, if_icache_req_o}, {31'd0, model_requesting()});
        check_eq("addr",  if_icache_addr_o, m_pc);
        check_eq("valid", {31'd0, if_valid_o}, {31'd0, m_valid});
        check_eq("pc",    if_pc_o, m_pco);
        check_eq("inst",  if_inst_o, m_insto);
`ifdef IF_FETCH_CNT_EN
        check_eq("cnt",   if_fetch_cnt_o, m_cnt);
`endif
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic step(input bit bt, input logic [31:0] bta, input bit jt, input logic [31:0] jta,
                        input bit st, input bit rdy, input bit ven);
        bit          resp, acc;
        logic [31:0] acc_addr;
        resp = st_pend && ven;
        fc_flush_btype_flag_i = bt;
        fc_btype_addr_i       = bta;
        fc_flush_jtype_flag_i = jt;
        fc_jtype_addr_i       = jta;
        fc_stall_if_i         = st;
        icache_if_ready_i     = rdy;
        icache_if_valid_i     = resp;
        icache_if_inst_i      = resp ? inst_of(st_addr) : $urandom;
        acc      = if_icache_req_o && rdy;
        acc_addr = if_icache_addr_o;
        @(posedge clk);
        model_update(bt, bta, jt, jta, st, rdy, resp, icache_if_inst_i);
        if (resp) st_pend = 0;
        if (acc) begin
            st_pend = 1;
            st_addr = acc_addr;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fc_flush_btype_flag_i = 0; fc_flush_jtype_flag_i = 0; fc_stall_if_i = 0;
        icache_if_ready_i = 0; icache_if_valid_i = 0;
        #1;
        model_reset();
        st_pend = 0;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    // Idle the ICache side until the model expects a presented request.
    task automatic wait_req();
        int n;
        n = 0;
        while (!model_requesting() && n < 20) begin
            step(0, 0, 0, 0, 0, 0, 1);
            n++;
        end
        check_eq("wait_req_timeout", {31'd0, model_requesting()}, 32'd1);
    endtask

    logic [31:0] got_pcs[$];
    bit          r_stall;

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Straight-line fetch with an always-ready ICache.
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1, 1);
            if (if_valid_o) got_pcs.push_back(if_pc_o);
        end
        check_eq("seq_count_ge3", {31'd0, got_pcs.size() >= 3}, 32'd1);
        if (got_pcs.size() >= 3) begin
            check_eq("seq_pc0", got_pcs[0], 32'h0);
            check_eq("seq_pc1", got_pcs[1], 32'h4);
            check_eq("seq_pc2", got_pcs[2], 32'h8);
        end

        // Request held while ICache is not ready.
        wait_req();
        step(0, 0, 1, 32'h10, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            check_eq("nrdy_req",   {31'd0, if_icache_req_o}, 32'd1);
            check_eq("nrdy_addr",  if_icache_addr_o, 32'h10);
            check_eq("nrdy_valid", {31'd0, if_valid_o}, 32'd0);
        end

        // Stall on delivery of 0x20.
        step(1, 32'h20, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        check_eq("stall_dlv_pc", if_pc_o, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1, 1);
            check_eq("hold_pc",    if_pc_o, 32'h20);
            check_eq("hold_valid", {31'd0, if_valid_o}, 32'd1);
            check_eq("hold_req",   {31'd0, if_icache_req_o}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("unstall_req",  {31'd0, if_icache_req_o}, 32'd1);
        check_eq("unstall_addr", if_icache_addr_o, 32'h24);

        // Branch while waiting on 0x30: stale response dropped.
        step(1, 32'h30, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h100, 0, 0, 0, 0, 0);
        check_eq("drop_valid0", {31'd0, if_valid_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("drop_valid1", {31'd0, if_valid_o}, 32'd0);
        check_eq("drop_addr",   if_icache_addr_o, 32'h100);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("redir_valid", {31'd0, if_valid_o}, 32'd1);
        check_eq("redir_pc",    if_pc_o, 32'h100);

        // Both redirects at once, unaligned targets: branch wins, bits [1:0] cleared.
        step(1, 32'h202, 1, 32'h301, 0, 0, 1);
        check_eq("prio_addr", if_icache_addr_o, 32'h200);

        // Address wrap at the top of memory.
        step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 1);
        check_eq("wrap_tgt", if_icache_addr_o, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("wrap_pc",   if_pc_o, 32'hFFFF_FFFC);
        check_eq("wrap_next", if_icache_addr_o, 32'h0);

        // Reset while a fetch is outstanding.
        step(0, 0, 0, 0, 0, 1, 0);
        do_reset();

        // Randomized traffic with occasional resets.
        r_stall = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          bt, jt;
            logic [31:0] bta, jta;
            if ($urandom_range(0, 5) == 0) r_stall = ~r_stall;
            bt  = ($urandom_range(0, 11) == 0);
            jt  = ($urandom_range(0, 11) == 0);
            bta = $urandom;
            jta = $urandom;
            if ($urandom_range(0, 30) == 0) bta = 32'hFFFF_FFFC;
            step(bt, bta, jt, jta, r_stall, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 249) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
